// File: rtl/reset_sequencer.sv
// Sequenced reset controller: releases DOMAINS active-high resets in index order, each gated on ready.
// Optional ready timeout with sticky error reporting is enabled by defining RSTSEQ_TIMEOUT_EN.
module reset_sequencer #(
    parameter int DOMAINS        = 4,
    parameter int HOLD_CYCLES    = 32,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               req_i,
    output logic               ack_o,
    output logic [DOMAINS-1:0] rst_o,
    input  logic [DOMAINS-1:0] ready_i,
    output logic               busy_o,
    output logic               err_o,
    output logic [3:0]         err_dom_o
);

    localparam int MAX_HG  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int MAX_CNT = (MAX_HG > TIMEOUT_CYCLES) ? MAX_HG : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam int KW      = (DOMAINS > 1) ? $clog2(DOMAINS) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [KW-1:0]    K_LAST    = KW'(DOMAINS - 1);

    typedef enum logic [1:0] {
        S_HOLD,
        S_WAIT,
        S_GAP,
        S_DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] counter;
    logic [KW-1:0]    k;
    logic [KW-1:0]    k_next;
    logic             req_seq;
    logic             ready_k;
    logic             advance;

    assign k_next  = k + KW'(1);
    assign ready_k = ready_i[k];

`ifdef RSTSEQ_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    // A timeout only fires when ready is absent; ready on the same edge wins.
    logic timeout_hit;
    assign timeout_hit = (counter == TO_LAST) && !ready_k;
    assign advance     = ready_k || timeout_hit;
`else
    assign advance     = ready_k;
    assign err_o       = 1'b0;
    assign err_dom_o   = 4'd0;
`endif

    // req_seq remembers that the running sequence came from a request, so power-on never acks.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= S_HOLD;
            counter   <= '0;
            k         <= '0;
            rst_o     <= '1;
            busy_o    <= 1'b1;
            ack_o     <= 1'b0;
            req_seq   <= 1'b0;
`ifdef RSTSEQ_TIMEOUT_EN
            err_o     <= 1'b0;
            err_dom_o <= 4'd0;
`endif
        end else begin
            case (state)
                S_HOLD: begin
                    if (counter == HOLD_LAST) begin
                        rst_o[0] <= 1'b0;
                        k        <= '0;
                        counter  <= '0;
                        state    <= S_WAIT;
                    end else begin
                        counter <= counter + CNT_W'(1);
                    end
                end
                S_WAIT: begin
`ifdef RSTSEQ_TIMEOUT_EN
                    if (timeout_hit) begin
                        err_o <= 1'b1;
                        if (!err_o) err_dom_o <= 4'(k);
                    end
`endif
                    if (advance) begin
                        counter <= '0;
                        if (k == K_LAST) begin
                            state   <= S_DONE;
                            busy_o  <= 1'b0;
                            ack_o   <= req_seq;
                            req_seq <= 1'b0;
                        end else if (GAP_CYCLES == 0) begin
                            rst_o[k_next] <= 1'b0;
                            k             <= k_next;
                        end else begin
                            state <= S_GAP;
                        end
                    end else begin
`ifdef RSTSEQ_TIMEOUT_EN
                        counter <= counter + CNT_W'(1);
`endif
                    end
                end
                S_GAP: begin
                    if (counter == GAP_LAST) begin
                        rst_o[k_next] <= 1'b0;
                        k             <= k_next;
                        counter       <= '0;
                        state         <= S_WAIT;
                    end else begin
                        counter <= counter + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (ack_o) begin
                        if (!req_i) ack_o <= 1'b0;
                    end else if (req_i) begin
                        rst_o     <= '1;
                        busy_o    <= 1'b1;
                        k         <= '0;
                        counter   <= '0;
                        req_seq   <= 1'b1;
                        state     <= S_HOLD;
`ifdef RSTSEQ_TIMEOUT_EN
                        err_o     <= 1'b0;
                        err_dom_o <= 4'd0;
`endif
                    end
                end
                default: state <= S_HOLD;
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default, zero-gap and short-timeout instances share clock and reset.
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_main = 1'b0;
    logic       req_to = 1'b0;
    logic [3:0] ready_main = 4'hF;
    logic [3:0] ready_g0 = 4'hF;
    logic [3:0] ready_to = 4'b1011;

    logic       ack_main, busy_main, err_main;
    logic [3:0] rst_main, dom_main;
    logic       ack_g0, busy_g0, err_g0;
    logic [3:0] rst_g0, dom_g0;
    logic       ack_to, busy_to, err_to;
    logic [3:0] rst_to, dom_to;

    int n_checks = 0;
    int n_errors = 0;
    int edge_cnt = 0;

    always #5 clk = ~clk;

    reset_sequencer #(.DOMAINS(4), .HOLD_CYCLES(32), .GAP_CYCLES(16), .TIMEOUT_CYCLES(1024)) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req_main), .ack_o(ack_main), .rst_o(rst_main),
        .ready_i(ready_main), .busy_o(busy_main), .err_o(err_main), .err_dom_o(dom_main)
    );

    reset_sequencer #(.DOMAINS(4), .HOLD_CYCLES(32), .GAP_CYCLES(0), .TIMEOUT_CYCLES(1024)) dut_g0 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(1'b0), .ack_o(ack_g0), .rst_o(rst_g0),
        .ready_i(ready_g0), .busy_o(busy_g0), .err_o(err_g0), .err_dom_o(dom_g0)
    );

    reset_sequencer #(.DOMAINS(4), .HOLD_CYCLES(32), .GAP_CYCLES(16), .TIMEOUT_CYCLES(8)) dut_to (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req_to), .ack_o(ack_to), .rst_o(rst_to),
        .ready_i(ready_to), .busy_o(busy_to), .err_o(err_to), .err_dom_o(dom_to)
    );

    typedef struct {
        int         cyc;
        logic       req;
        logic [3:0] rst;
        logic       busy;
        logic       ack;
        logic [3:0] rst_g0;
        logic       busy_g0;
    } vec_t;

    vec_t vecs [18];

    logic [3:0] e_rst_to;
    logic       e_busy_to;
    logic       e_err_to;
    logic [3:0] e_dom_to;

    // Each call advances n rising edges and leaves the bench 1 time unit past the last one.
    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            edge_cnt++;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0]  = '{31, 1'b0, 4'hF, 1'b1, 1'b0, 4'hF, 1'b1};
        vecs[1]  = '{32, 1'b0, 4'hE, 1'b1, 1'b0, 4'hE, 1'b1};
        vecs[2]  = '{33, 1'b0, 4'hE, 1'b1, 1'b0, 4'hC, 1'b1};
        vecs[3]  = '{34, 1'b0, 4'hE, 1'b1, 1'b0, 4'h8, 1'b1};
        vecs[4]  = '{35, 1'b0, 4'hE, 1'b1, 1'b0, 4'h0, 1'b1};
        vecs[5]  = '{36, 1'b0, 4'hE, 1'b1, 1'b0, 4'h0, 1'b0};
        vecs[6]  = '{48, 1'b1, 4'hE, 1'b1, 1'b0, 4'h0, 1'b0};
        vecs[7]  = '{49, 1'b0, 4'hC, 1'b1, 1'b0, 4'h0, 1'b0};
        vecs[8]  = '{65, 1'b0, 4'hC, 1'b1, 1'b0, 4'h0, 1'b0};
        vecs[9]  = '{66, 1'b0, 4'h8, 1'b1, 1'b0, 4'h0, 1'b0};
        vecs[10] = '{73, 1'b0, 4'h8, 1'b1, 1'b0, 4'h0, 1'b0};
        vecs[11] = '{74, 1'b0, 4'h8, 1'b1, 1'b0, 4'h0, 1'b0};
        vecs[12] = '{82, 1'b0, 4'h8, 1'b1, 1'b0, 4'h0, 1'b0};
        vecs[13] = '{83, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 1'b0};
        vecs[14] = '{84, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0};
        vecs[15] = '{89, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0};
        vecs[16] = '{90, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0};
        vecs[17] = '{91, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0};

        // Reset values while rst_n is held low.
        applyStimulus(3);
        checkOutput("reset rst", 32'(rst_main), 32'hF);
        checkOutput("reset busy", 32'(busy_main), 32'h1);
        checkOutput("reset ack", 32'(ack_main), 32'h0);
        checkOutput("reset err", 32'(err_main), 32'h0);
        checkOutput("reset err_dom", 32'(dom_main), 32'h0);
        checkOutput("reset rst_g0", 32'(rst_g0), 32'hF);

        @(negedge clk);
        rst_n    = 1'b1;
        edge_cnt = 0;

        // Power-on sequence on all three instances; the short-timeout one has ready_i[2] stuck low.
        for (int i = 0; i < 18; i++) begin
            int c;
            c = vecs[i].cyc;
            while (edge_cnt < c) applyStimulus(1);
            e_rst_to = (c < 32) ? 4'hF : (c < 49) ? 4'hE : (c < 66) ? 4'hC : 4'h8;
`ifdef RSTSEQ_TIMEOUT_EN
            if (c >= 90) e_rst_to = 4'h0;
            e_busy_to = (c < 91);
            e_err_to  = (c >= 74);
            e_dom_to  = (c >= 74) ? 4'd2 : 4'd0;
`else
            e_busy_to = 1'b1;
            e_err_to  = 1'b0;
            e_dom_to  = 4'd0;
`endif
            checkOutput($sformatf("main rst@%0d", c), 32'(rst_main), 32'(vecs[i].rst));
            checkOutput($sformatf("main busy@%0d", c), 32'(busy_main), 32'(vecs[i].busy));
            checkOutput($sformatf("main ack@%0d", c), 32'(ack_main), 32'(vecs[i].ack));
            checkOutput($sformatf("g0 rst@%0d", c), 32'(rst_g0), 32'(vecs[i].rst_g0));
            checkOutput($sformatf("g0 busy@%0d", c), 32'(busy_g0), 32'(vecs[i].busy_g0));
            checkOutput($sformatf("to rst@%0d", c), 32'(rst_to), 32'(e_rst_to));
            checkOutput($sformatf("to busy@%0d", c), 32'(busy_to), 32'(e_busy_to));
            checkOutput($sformatf("to err@%0d", c), 32'(err_to), 32'(e_err_to));
            checkOutput($sformatf("to err_dom@%0d", c), 32'(dom_to), 32'(e_dom_to));
            req_main = vecs[i].req;
        end

        // Re-reset by request: accept, replay with power-on timing, then ack handshake.
        req_main = 1'b1;
        req_to   = 1'b1;
        applyStimulus(1);
        req_to   = 1'b0;
        checkOutput("rereq rst", 32'(rst_main), 32'hF);
        checkOutput("rereq busy", 32'(busy_main), 32'h1);
        checkOutput("rereq ack", 32'(ack_main), 32'h0);
`ifdef RSTSEQ_TIMEOUT_EN
        checkOutput("to err cleared", 32'(err_to), 32'h0);
        checkOutput("to err_dom cleared", 32'(dom_to), 32'h0);
        checkOutput("to rst rereq", 32'(rst_to), 32'hF);
`else
        checkOutput("to err tied", 32'(err_to), 32'h0);
        checkOutput("to still waiting", 32'(rst_to), 32'h8);
`endif
        applyStimulus(31);
        checkOutput("rereq rst@31", 32'(rst_main), 32'hF);
        applyStimulus(1);
        checkOutput("rereq rst@32", 32'(rst_main), 32'hE);
        applyStimulus(17);
        checkOutput("rereq rst@49", 32'(rst_main), 32'hC);
        applyStimulus(17);
        checkOutput("rereq rst@66", 32'(rst_main), 32'h8);
        applyStimulus(17);
        checkOutput("rereq rst@83", 32'(rst_main), 32'h0);
        checkOutput("rereq busy@83", 32'(busy_main), 32'h1);
        checkOutput("rereq ack@83", 32'(ack_main), 32'h0);
        applyStimulus(1);
        checkOutput("rereq busy@84", 32'(busy_main), 32'h0);
        checkOutput("rereq ack@84", 32'(ack_main), 32'h1);
        applyStimulus(20);
        checkOutput("held req ack", 32'(ack_main), 32'h1);
        checkOutput("held req busy", 32'(busy_main), 32'h0);
        checkOutput("held req rst", 32'(rst_main), 32'h0);
        req_main = 1'b0;
        applyStimulus(1);
        checkOutput("ack drop", 32'(ack_main), 32'h0);
        checkOutput("ack drop busy", 32'(busy_main), 32'h0);

        // Late ready on domain 1: the gap is measured from when ready rises.
        ready_main = 4'b1101;
        req_main   = 1'b1;
        applyStimulus(50);
        checkOutput("late rst@49", 32'(rst_main), 32'hC);
        applyStimulus(100);
        checkOutput("late rst stalled", 32'(rst_main), 32'hC);
        ready_main = 4'hF;
        applyStimulus(16);
        checkOutput("late rst@+16", 32'(rst_main), 32'hC);
        applyStimulus(1);
        checkOutput("late rst@+17", 32'(rst_main), 32'h8);
        checkOutput("late err", 32'(err_main), 32'h0);
        applyStimulus(18);
        checkOutput("late rst done", 32'(rst_main), 32'h0);
        checkOutput("late ack", 32'(ack_main), 32'h1);
        checkOutput("late busy", 32'(busy_main), 32'h0);
        req_main = 1'b0;
        applyStimulus(1);
        checkOutput("late ack drop", 32'(ack_main), 32'h0);

        // Asynchronous reset in the middle of the domain-1 gap.
        req_main = 1'b1;
        applyStimulus(1);
        req_main = 1'b0;
        applyStimulus(55);
        checkOutput("midgap rst", 32'(rst_main), 32'hC);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async rst", 32'(rst_main), 32'hF);
        checkOutput("async busy", 32'(busy_main), 32'h1);
        checkOutput("async ack", 32'(ack_main), 32'h0);
        @(negedge clk);
        rst_n    = 1'b1;
        edge_cnt = 0;
        applyStimulus(31);
        checkOutput("restart rst@31", 32'(rst_main), 32'hF);
        applyStimulus(1);
        checkOutput("restart rst@32", 32'(rst_main), 32'hE);
        checkOutput("restart busy", 32'(busy_main), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
